region_color_tally: RTL and testbench

REGION_COLOR_TALLY -- requirements
Module: region_color_tally

---
 rtl/region_color_tally_pkg.sv | 25 ++
 rtl/region_color_tally_argmax.sv | 36 +++
 rtl/region_color_tally.sv | 235 +++++++++++++++++++++++
 tb/tb_region_color_tally.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/region_color_tally_pkg.sv
// Shared definitions for the region colour tally: class codes, FSM encoding
// and a width helper used to size counters.
package colorDetect_definitions;

  localparam logic [2:0] NONE   = 3'd0;
  localparam logic [2:0] RED    = 3'd1;
  localparam logic [2:0] ORANGE = 3'd2;
  localparam logic [2:0] YELLOW = 3'd3;
  localparam logic [2:0] GREEN  = 3'd4;
  localparam logic [2:0] BLUE   = 3'd5;
  localparam logic [2:0] WHITE  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_SCAN    = 2'd2,
    ST_PUBLISH = 2'd3
  } tally_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/region_color_tally_argmax.sv
// Combinational argmax over one region's class tallies; ties resolve to the
// lowest class, and a winner below MIN_PIXELS reports code 0.
module region_argmax #(
  parameter int NUM_COLORS = 6,
  parameter int CNT_W      = 18,
  parameter int MIN_PIXELS = 64,
  parameter int CW         = 3
) (
  input  logic [NUM_COLORS*CNT_W-1:0] i_tallies,
  output logic [CW-1:0]               o_code
);

  localparam logic [CNT_W:0] MIN_V = (CNT_W+1)'(MIN_PIXELS);

  logic [CNT_W-1:0] best_cnt_s;
  logic [CNT_W-1:0] cand_s;
  logic [CW-1:0]    best_idx_s;

  // Strict greater-than keeps the earliest class on equal counts.
  always_comb begin
    best_cnt_s = i_tallies[CNT_W-1:0];
    best_idx_s = {CW{1'b0}};
    cand_s     = {CNT_W{1'b0}};
    for (int k = 1; k < NUM_COLORS; k++) begin
      cand_s     = i_tallies[k*CNT_W +: CNT_W];
      best_idx_s = (cand_s > best_cnt_s) ? CW'(k) : best_idx_s;
      best_cnt_s = (cand_s > best_cnt_s) ? cand_s : best_cnt_s;
    end
    if ({1'b0, best_cnt_s} >= MIN_V) begin
      o_code = best_idx_s + CW'(1'b1);
    end else begin
      o_code = {CW{1'b0}};
    end
  end

endmodule

// File: rtl/region_color_tally.sv
// Per-region colour class tally over a raster frame; after the last pixel a
// one-region-per-cycle scan picks each region's winner and publishes them.
module region_color_tally
  import colorDetect_definitions::*;
#(
  parameter int FRAME_W    = 480,
  parameter int FRAME_H    = 480,
  parameter int GRID_X     = 3,
  parameter int GRID_Y     = 3,
  parameter int NUM_COLORS = 6,
  parameter int CNT_W      = 18,
  parameter int MIN_PIXELS = 64
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic                                           i_sof,
  input  logic                                           i_valid,
  input  logic [$clog2(NUM_COLORS+1)-1:0]                i_color,
  output logic [GRID_X*GRID_Y*$clog2(NUM_COLORS+1)-1:0]  o_result,
  output logic                                           o_result_valid,
  output logic                                           o_busy,
  output logic                                           o_drop
);

  localparam int CW  = $clog2(NUM_COLORS+1);
  localparam int R   = GRID_X*GRID_Y;
  localparam int RW  = FRAME_W/GRID_X;
  localparam int RH  = FRAME_H/GRID_Y;
  localparam int XW  = width_of(FRAME_W);
  localparam int YW  = width_of(FRAME_H);
  localparam int SXW = width_of(RW);
  localparam int SYW = width_of(RH);
  localparam int RIW = width_of(R);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  tally_state_t state_r, state_s;

  logic [XW-1:0]  x_cnt_r;
  logic [YW-1:0]  y_cnt_r;
  logic [SXW-1:0] sub_x_r;
  logic [SYW-1:0] sub_y_r;
  logic [RIW-1:0] reg_col_r;
  logic [RIW-1:0] row_base_r;
  logic [RIW-1:0] reg_idx_s;
  logic [RIW-1:0] scan_idx_r;

  logic [CNT_W-1:0] tally_r [R][NUM_COLORS];
  logic [CW-1:0]    shadow_r [R];

  logic                        last_pix_s, count_s, clear_s, drop_s;
  logic                        pend_set_s, pend_r, color_ok_s;
  logic [CW-1:0]               cls_s, code_s;
  logic [NUM_COLORS*CNT_W-1:0] scan_vec_s;
  logic [R*CW-1:0]             shadow_vec_s;

  assign last_pix_s = (x_cnt_r == XW'(FRAME_W-1)) && (y_cnt_r == YW'(FRAME_H-1));
  assign reg_idx_s  = row_base_r + reg_col_r;
  assign color_ok_s = (i_color != {CW{1'b0}}) && (i_color <= CW'(NUM_COLORS));
  assign cls_s      = i_color - CW'(1'b1);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s    = state_r;
    count_s    = 1'b0;
    clear_s    = 1'b0;
    drop_s     = 1'b0;
    pend_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_sof) begin
          state_s = ST_ACCUM;
          clear_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // The final pixel wins over a coincident sof; the sof is deferred.
        if (i_valid && last_pix_s) begin
          count_s    = 1'b1;
          pend_set_s = i_sof;
          state_s    = ST_SCAN;
        end else if (i_sof) begin
          clear_s = 1'b1;
        end else if (i_valid) begin
          count_s = 1'b1;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_SCAN: begin
        drop_s     = i_valid;
        pend_set_s = i_sof;
        if (scan_idx_r == RIW'(R-1)) begin
          state_s = ST_PUBLISH;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_PUBLISH: begin
        drop_s  = i_valid;
        clear_s = 1'b1;
        if (pend_r || i_sof) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Raster coordinates plus region sub-counters; no division needed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || clear_s) begin
      x_cnt_r    <= {XW{1'b0}};
      y_cnt_r    <= {YW{1'b0}};
      sub_x_r    <= {SXW{1'b0}};
      sub_y_r    <= {SYW{1'b0}};
      reg_col_r  <= {RIW{1'b0}};
      row_base_r <= {RIW{1'b0}};
    end else if (count_s) begin
      if (x_cnt_r == XW'(FRAME_W-1)) begin
        x_cnt_r   <= {XW{1'b0}};
        sub_x_r   <= {SXW{1'b0}};
        reg_col_r <= {RIW{1'b0}};
        if (y_cnt_r == YW'(FRAME_H-1)) begin
          y_cnt_r    <= {YW{1'b0}};
          sub_y_r    <= {SYW{1'b0}};
          row_base_r <= {RIW{1'b0}};
        end else begin
          y_cnt_r <= y_cnt_r + YW'(1'b1);
          if (sub_y_r == SYW'(RH-1)) begin
            sub_y_r    <= {SYW{1'b0}};
            row_base_r <= row_base_r + RIW'(GRID_X);
          end else begin
            sub_y_r <= sub_y_r + SYW'(1'b1);
          end
        end
      end else begin
        x_cnt_r <= x_cnt_r + XW'(1'b1);
        if (sub_x_r == SXW'(RW-1)) begin
          sub_x_r   <= {SXW{1'b0}};
          reg_col_r <= reg_col_r + RIW'(1'b1);
        end else begin
          sub_x_r <= sub_x_r + SXW'(1'b1);
        end
      end
    end
  end

  // Saturating per-region, per-class tallies.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || clear_s) begin
      for (int r = 0; r < R; r++) begin
        for (int k = 0; k < NUM_COLORS; k++) begin
          tally_r[r][k] <= {CNT_W{1'b0}};
        end
      end
    end else if (count_s && color_ok_s && (tally_r[reg_idx_s][cls_s] != CNT_MAX)) begin
      tally_r[reg_idx_s][cls_s] <= tally_r[reg_idx_s][cls_s] + CNT_W'(1'b1);
    end
  end

  // Present the region under scan to the argmax and pack the shadow MSB-first.
  always_comb begin
    scan_vec_s   = {(NUM_COLORS*CNT_W){1'b0}};
    shadow_vec_s = {(R*CW){1'b0}};
    for (int k = 0; k < NUM_COLORS; k++) begin
      scan_vec_s[k*CNT_W +: CNT_W] = tally_r[scan_idx_r][k];
    end
    for (int r = 0; r < R; r++) begin
      shadow_vec_s[(R-1-r)*CW +: CW] = shadow_r[r];
    end
  end

  region_argmax #(
    .NUM_COLORS (NUM_COLORS),
    .CNT_W      (CNT_W),
    .MIN_PIXELS (MIN_PIXELS),
    .CW         (CW)
  ) u_argmax (
    .i_tallies (scan_vec_s),
    .o_code    (code_s)
  );

  // Scan index and shadow winners.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scan_idx_r <= {RIW{1'b0}};
      for (int r = 0; r < R; r++) begin
        shadow_r[r] <= {CW{1'b0}};
      end
    end else if (state_r == ST_SCAN) begin
      shadow_r[scan_idx_r] <= code_s;
      scan_idx_r <= (scan_idx_r == RIW'(R-1)) ? {RIW{1'b0}} : scan_idx_r + RIW'(1'b1);
    end else begin
      scan_idx_r <= {RIW{1'b0}};
    end
  end

  // Registered outputs and the deferred-sof flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result       <= {(R*CW){1'b0}};
      o_result_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_drop         <= 1'b0;
      pend_r         <= 1'b0;
    end else begin
      o_result_valid <= (state_r == ST_PUBLISH);
      o_busy         <= (state_s == ST_SCAN) || (state_s == ST_PUBLISH);
      o_drop         <= drop_s;
      if (state_r == ST_PUBLISH) begin
        o_result <= shadow_vec_s;
        pend_r   <= 1'b0;
      end else if (pend_set_s) begin
        pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_region_color_tally.sv
// Randomised self-checking bench for region_color_tally on a 6x6 frame with
// a 3x3 grid; expectations come from a per-pixel counting model.
module tb_region_color_tally;
  import colorDetect_definitions::*;

  localparam int FW = 6, FH = 6, GX = 3, GY = 3, NC = 6, CNTW = 18, MINP = 2;
  localparam int CW = 3, R = GX*GY, NPIX = FW*FH, RES_W = R*CW, LAT = R+2;

  logic i_clk = 1'b0;
  logic i_rst, i_sof, i_valid;
  logic [CW-1:0] i_color;
  logic [RES_W-1:0] o_result;
  logic o_result_valid, o_busy, o_drop;

  region_color_tally #(
    .FRAME_W(FW), .FRAME_H(FH), .GRID_X(GX), .GRID_Y(GY),
    .NUM_COLORS(NC), .CNT_W(CNTW), .MIN_PIXELS(MINP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sof(i_sof), .i_valid(i_valid),
    .i_color(i_color), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int valid_cnt = 0, drop_cnt = 0, busy_cnt = 0, res_glitch = 0, valid_cyc = 0;
  logic [RES_W-1:0] valid_res = '0, prev_res = '0;

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_result_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      valid_res <= o_result;
    end
    if (o_drop) drop_cnt <= drop_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
    if (!i_rst && !o_result_valid && (o_result !== prev_res)) res_glitch <= res_glitch + 1;
    prev_res <= o_result;
  end

  int n_checks = 0, n_pass = 0;
  int frame [NPIX];
  int last_pix_cyc = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: count every pixel into its region by coordinate division.
  function automatic logic [RES_W-1:0] model_result();
    int cnt [R][NC];
    int best, idx, reg_i, c;
    logic [RES_W-1:0] res;
    res = '0;
    for (int r = 0; r < R; r++) for (int k = 0; k < NC; k++) cnt[r][k] = 0;
    for (int p = 0; p < NPIX; p++) begin
      reg_i = ((p / FW) / (FH / GY)) * GX + (p % FW) / (FW / GX);
      c = frame[p];
      if (c >= 1 && c <= NC) cnt[reg_i][c-1] = cnt[reg_i][c-1] + 1;
    end
    for (int r = 0; r < R; r++) begin
      best = -1;
      idx = 0;
      for (int k = 0; k < NC; k++) if (cnt[r][k] > best) begin best = cnt[r][k]; idx = k; end
      res[(R-1-r)*CW +: CW] = (best >= MINP) ? CW'(idx + 1) : 3'd0;
    end
    return res;
  endfunction

  task automatic send_sof();
    i_sof = 1'b1;
    step();
    i_sof = 1'b0;
  endtask

  task automatic send_frame(input bit with_sof, input bit gaps, input int overrun, input bit sof_last);
    if (with_sof) send_sof();
    for (int p = 0; p < NPIX; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        step();
      end
      i_valid = 1'b1;
      i_color = CW'(frame[p]);
      if (p == NPIX-1 && sof_last) i_sof = 1'b1;
      last_pix_cyc = cyc;
      step();
      i_sof = 1'b0;
    end
    for (int i = 0; i < overrun; i++) begin
      i_color = CW'($urandom_range(1, NC));
      step();
    end
    i_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int p = 0; p < NPIX; p++) frame[p] = $urandom_range(0, 7);
  endtask

  task automatic test_reset();
    int d0, b0;
    i_rst = 1'b1; i_sof = 1'b0; i_valid = 1'b0; i_color = '0;
    repeat (3) step();
    n_checks++; if (o_result !== '0) $display("FAIL reset_result: got %h want 0", o_result); else n_pass++;
    n_checks++; if ({o_result_valid, o_busy, o_drop} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {o_result_valid, o_busy, o_drop}); else n_pass++;
    i_rst = 1'b0;
    step();
    d0 = drop_cnt; b0 = busy_cnt;
    i_valid = 1'b1; i_color = GREEN;
    repeat (5) step();
    i_valid = 1'b0;
    repeat (3) step();
    n_checks++; if (drop_cnt - d0 !== 0) $display("FAIL idle_drop: got %0d want 0", drop_cnt - d0); else n_pass++;
    n_checks++; if (busy_cnt - b0 !== 0) $display("FAIL idle_busy: got %0d want 0", busy_cnt - b0); else n_pass++;
  endtask

  task automatic test_uniform();
    int v0, b0, d0;
    for (int p = 0; p < NPIX; p++) frame[p] = int'(GREEN);
    v0 = valid_cnt; b0 = busy_cnt; d0 = drop_cnt;
    send_frame(1'b1, 1'b0, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL uniform_pulses: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (valid_cyc - last_pix_cyc !== LAT)
      $display("FAIL uniform_latency: got %0d want %0d", valid_cyc - last_pix_cyc, LAT); else n_pass++;
    n_checks++; if (valid_res !== 27'o444444444) $display("FAIL uniform_result: got %o want 444444444", valid_res); else n_pass++;
    n_checks++; if (busy_cnt - b0 !== R + 1) $display("FAIL uniform_busy: got %0d want %0d", busy_cnt - b0, R + 1); else n_pass++;
    n_checks++; if (drop_cnt - d0 !== 0) $display("FAIL uniform_drop: got %0d want 0", drop_cnt - d0); else n_pass++;
  endtask

  task automatic test_per_region();
    for (int p = 0; p < NPIX; p++) frame[p] = (((p / FW) / 2) * GX + (p % FW) / 2) % 6 + 1;
    send_frame(1'b1, 1'b1, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (o_result !== 27'o123456123) $display("FAIL per_region: got %o want 123456123", o_result); else n_pass++;
  endtask

  task automatic test_tie_threshold();
    logic [RES_W-1:0] exp_r;
    fill_random();
    frame[0] = int'(BLUE); frame[1] = int'(RED); frame[6] = int'(BLUE); frame[7] = int'(RED);
    frame[2] = int'(GREEN); frame[3] = int'(NONE); frame[8] = int'(NONE); frame[9] = int'(NONE);
    exp_r = model_result();
    send_frame(1'b1, 1'b1, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (o_result[26:24] !== 3'd1) $display("FAIL tie_region0: got %0d want 1", o_result[26:24]); else n_pass++;
    n_checks++; if (o_result[23:21] !== 3'd0) $display("FAIL thresh_region1: got %0d want 0", o_result[23:21]); else n_pass++;
    n_checks++; if (o_result !== exp_r) $display("FAIL tie_full: got %o want %o", o_result, exp_r); else n_pass++;
  endtask

  task automatic test_random();
    logic [RES_W-1:0] exp_r;
    int v0;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      exp_r = model_result();
      v0 = valid_cnt;
      send_frame(1'b1, 1'b1, 0, 1'b0);
      repeat (LAT + 4) step();
      n_checks++; if (valid_res !== exp_r) $display("FAIL random_result%0d: got %o want %o", f, valid_res, exp_r); else n_pass++;
      n_checks++; if ((valid_cnt - v0 !== 1) || (valid_cyc - last_pix_cyc !== LAT))
        $display("FAIL random_timing%0d: pulses %0d latency %0d want 1 and %0d", f, valid_cnt - v0, valid_cyc - last_pix_cyc, LAT);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [RES_W-1:0] exp_r;
    int d0;
    fill_random();
    exp_r = model_result();
    d0 = drop_cnt;
    send_frame(1'b1, 1'b0, 3, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (drop_cnt - d0 !== 3) $display("FAIL overrun_drops: got %0d want 3", drop_cnt - d0); else n_pass++;
    n_checks++; if (o_result !== exp_r) $display("FAIL overrun_result: got %o want %o", o_result, exp_r); else n_pass++;
  endtask

  task automatic test_midframe_sof();
    int v0;
    v0 = valid_cnt;
    send_sof();
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1; i_color = BLUE;
      step();
    end
    i_valid = 1'b0;
    for (int p = 0; p < NPIX; p++) frame[p] = int'(ORANGE);
    send_frame(1'b1, 1'b0, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL midsof_pulses: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_checks++; if (o_result !== 27'o222222222) $display("FAIL midsof_result: got %o want 222222222", o_result); else n_pass++;
  endtask

  task automatic test_reset_scan();
    logic [RES_W-1:0] exp_r;
    int v0;
    for (int p = 0; p < NPIX; p++) frame[p] = int'(YELLOW);
    v0 = valid_cnt;
    send_frame(1'b1, 1'b0, 0, 1'b0);
    repeat (3) step();
    i_rst = 1'b1;
    #1;
    n_checks++; if ({o_busy, o_result} !== {1'b0, 27'o0}) $display("FAIL rstscan_async: busy %b result %o want 0 0", o_busy, o_result); else n_pass++;
    repeat (2) step();
    i_rst = 1'b0;
    repeat (LAT + 4) step();
    n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL rstscan_pulses: got %0d want 0", valid_cnt - v0); else n_pass++;
    n_checks++; if (o_result !== '0) $display("FAIL rstscan_result: got %o want 0", o_result); else n_pass++;
    fill_random();
    exp_r = model_result();
    send_frame(1'b1, 1'b1, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if (o_result !== exp_r) $display("FAIL rstscan_next: got %o want %o", o_result, exp_r); else n_pass++;
  endtask

  task automatic test_sof_on_last();
    logic [RES_W-1:0] exp_a, exp_b;
    int v0;
    fill_random();
    exp_a = model_result();
    v0 = valid_cnt;
    send_frame(1'b1, 1'b0, 0, 1'b1);
    repeat (LAT + 4) step();
    n_checks++; if (valid_res !== exp_a) $display("FAIL soflast_first: got %o want %o", valid_res, exp_a); else n_pass++;
    fill_random();
    exp_b = model_result();
    send_frame(1'b0, 1'b1, 0, 1'b0);
    repeat (LAT + 4) step();
    n_checks++; if ((valid_cnt - v0 !== 2) || (valid_res !== exp_b))
      $display("FAIL soflast_second: pulses %0d result %o want 2 and %o", valid_cnt - v0, valid_res, exp_b);
    else n_pass++;
  endtask

  task automatic test_result_stability();
    n_checks++; if (res_glitch !== 0) $display("FAIL result_stable: got %0d changes outside publish want 0", res_glitch); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_per_region();
    test_tie_threshold();
    test_random();
    test_overrun();
    test_midframe_sof();
    test_reset_scan();
    test_sof_on_last();
    test_result_stability();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
